// File: rtl/median_window3x3_if.sv
`default_nettype none
// ============================================================================
//  Module   : median_window3x3_if
//  Brief    : Pixel-in / 3x3-window-out stream bundle for median_window3x3.
//             MEDWIN_COORD_EN adds the m_x/m_y window-centre coordinates.
//  Revision : 1.0  initial release
// ============================================================================
interface median_window3x3_if;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_sof;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  w0, w1, w2, w3, w4, w5, w6, w7, w8;
    logic        frame_done;
`ifdef MEDWIN_COORD_EN
    logic [11:0] m_x;
    logic [11:0] m_y;
`endif

    // Upstream pixel source / downstream window sink.
    modport master (
        output s_valid, s_data, s_sof, m_ready,
        input  s_ready, m_valid, w0, w1, w2, w3, w4, w5, w6, w7, w8, frame_done
`ifdef MEDWIN_COORD_EN
        , input m_x, m_y
`endif
    );

    // Window generator.
    modport slave (
        input  s_valid, s_data, s_sof, m_ready,
        output s_ready, m_valid, w0, w1, w2, w3, w4, w5, w6, w7, w8, frame_done
`ifdef MEDWIN_COORD_EN
        , output m_x, m_y
`endif
    );
endinterface
`default_nettype wire

// File: rtl/median_window3x3.sv
`default_nettype none
// ============================================================================
//  Module   : median_window3x3
//  Brief    : Streaming 3x3 neighbourhood generator with two line buffers,
//             feeding a 9-input median network. Optional MEDWIN_COORD_EN.
//  Revision : 1.0  initial release
// ============================================================================
module median_window3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    median_window3x3_if.slave bus
);
    localparam int          c_AW      = $clog2(IMG_W);
    localparam logic [11:0] c_COL_MAX = 12'(IMG_W - 1);
    localparam logic [11:0] c_ROW_MAX = 12'(IMG_H - 1);

    logic [11:0]     r_col;
    logic [11:0]     r_row;
    logic [7:0]      r_lb0 [0:IMG_W-1];
    logic [7:0]      r_lb1 [0:IMG_W-1];
    logic [7:0]      r_win [0:2][0:2];
    logic [7:0]      r_w   [0:8];
    logic            r_m_valid;
    logic            r_frame_done;
`ifdef MEDWIN_COORD_EN
    logic [11:0]     r_m_x;
    logic [11:0]     r_m_y;
`endif

    logic            w_accept;
    logic            w_emit;
    logic            w_last;
    logic [11:0]     w_col;
    logic [11:0]     w_row;
    logic [c_AW-1:0] w_addr;
    logic [7:0]      w_top;
    logic [7:0]      w_mid;
    logic [7:0]      w_win [0:2][0:2];

    assign bus.s_ready = !r_m_valid || bus.m_ready;
    assign w_accept    = bus.s_valid && bus.s_ready;

    // A start-of-frame beat is pixel (0,0) regardless of where the counters are.
    assign w_col  = bus.s_sof ? 12'd0 : r_col;
    assign w_row  = bus.s_sof ? 12'd0 : r_row;
    assign w_addr = w_col[c_AW-1:0];
    assign w_top  = r_lb1[w_addr];
    assign w_mid  = r_lb0[w_addr];
    assign w_last = (w_col == c_COL_MAX) && (w_row == c_ROW_MAX);
    assign w_emit = w_accept && (w_row >= 12'd2) && (w_col >= 12'd2);

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                w_win[r][c] = bus.s_sof ? 8'h00 : r_win[r][c+1];
            end
        end
        w_win[0][2] = w_top;
        w_win[1][2] = w_mid;
        w_win[2][2] = bus.s_data;
    end

    // Line memories are deliberately unreset; the row>=2 gate hides stale data.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[w_addr] <= w_mid;
            r_lb0[w_addr] <= bus.s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_m_valid    <= 1'b0;
            r_frame_done <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
            for (int i = 0; i < 9; i++) begin
                r_w[i] <= '0;
            end
`ifdef MEDWIN_COORD_EN
            r_m_x <= '0;
            r_m_y <= '0;
`endif
        end else begin
            r_frame_done <= w_accept && w_last;
            if (w_accept) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        r_win[r][c] <= w_win[r][c];
                    end
                end
                if (w_col == c_COL_MAX) begin
                    r_col <= '0;
                    r_row <= (w_row == c_ROW_MAX) ? 12'd0 : w_row + 12'd1;
                end else begin
                    r_col <= w_col + 12'd1;
                    r_row <= w_row;
                end
            end
            // A fresh window takes priority over the downstream handshake clearing.
            if (w_emit) begin
                r_m_valid <= 1'b1;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        r_w[r*3+c] <= w_win[r][c];
                    end
                end
`ifdef MEDWIN_COORD_EN
                r_m_x <= w_col - 12'd1;
                r_m_y <= w_row - 12'd1;
`endif
            end else if (r_m_valid && bus.m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign bus.m_valid    = r_m_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.w0         = r_w[0];
    assign bus.w1         = r_w[1];
    assign bus.w2         = r_w[2];
    assign bus.w3         = r_w[3];
    assign bus.w4         = r_w[4];
    assign bus.w5         = r_w[5];
    assign bus.w6         = r_w[6];
    assign bus.w7         = r_w[7];
    assign bus.w8         = r_w[8];
`ifdef MEDWIN_COORD_EN
    assign bus.m_x        = r_m_x;
    assign bus.m_y        = r_m_y;
`endif
endmodule
`default_nettype wire

// File: tb/tb_median_window3x3.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_median_window3x3
//  Brief    : Self-checking bench: directed frames plus randomized traffic
//             against an image-array reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_median_window3x3;
    localparam int          W        = 5;
    localparam int          H        = 4;
    localparam logic [71:0] c_FIRST  = 72'h00_01_02_10_11_12_20_21_22;
    localparam logic [71:0] c_LAST   = 72'h12_13_14_22_23_24_32_33_34;
    localparam logic [71:0] c_F2     = 72'h80_81_82_90_91_92_a0_a1_a2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    median_window3x3_if bus ();
    median_window3x3 #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rdy_mode = 0;
    bit          gap_en   = 0;
    logic [7:0]  img [0:H-1][0:W-1];
    int          e_row    = 0;
    int          e_col    = 0;
    int          e_emits  = 0;
    int          n_done   = 0;
    bit          e_mvalid = 0;
    bit          e_done   = 0;
    logic [71:0] e_win    = '0;
    logic [23:0] e_xy     = '0;
    logic [71:0] got_q [$];
    logic [23:0] xy_q  [$];

    task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [71:0] win_act();
        return {bus.w0, bus.w1, bus.w2, bus.w3, bus.w4, bus.w5, bus.w6, bus.w7, bus.w8};
    endfunction

    function automatic logic [71:0] qget(input int idx);
        if (idx < 0 || idx >= got_q.size()) return 'x;
        return got_q[idx];
    endfunction

    function automatic logic [23:0] xyget(input int idx);
        if (idx < 0 || idx >= xy_q.size()) return 'x;
        return xy_q[idx];
    endfunction

    // Reference: store each accepted pixel at its raster position, build windows from the image.
    task automatic monitor_loop();
        bit acc;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                e_mvalid = 0;
                e_done   = 0;
                e_row    = 0;
                e_col    = 0;
                check("rst_m_valid", 72'(bus.m_valid), 72'd0);
                check("rst_frame_done", 72'(bus.frame_done), 72'd0);
                check("rst_window", win_act(), 72'd0);
            end else begin
                check("s_ready", 72'(bus.s_ready), 72'(!e_mvalid || bus.m_ready));
                check("m_valid", 72'(bus.m_valid), 72'(e_mvalid));
                check("frame_done", 72'(bus.frame_done), 72'(e_done));
                if (e_mvalid) begin
                    check("window", win_act(), e_win);
`ifdef MEDWIN_COORD_EN
                    check("coord", 72'({bus.m_x, bus.m_y}), 72'(e_xy));
`endif
                end
                if (bus.m_valid && bus.m_ready) begin
                    got_q.push_back(win_act());
`ifdef MEDWIN_COORD_EN
                    xy_q.push_back({bus.m_x, bus.m_y});
`endif
                end
                if (bus.frame_done) n_done++;

                acc    = bus.s_valid && (!e_mvalid || bus.m_ready);
                e_done = 0;
                if (e_mvalid && bus.m_ready) e_mvalid = 0;
                if (acc) begin
                    if (bus.s_sof) begin
                        e_row = 0;
                        e_col = 0;
                    end
                    img[e_row][e_col] = bus.s_data;
                    e_done = (e_row == H-1) && (e_col == W-1);
                    if (e_row >= 2 && e_col >= 2) begin
                        e_mvalid = 1;
                        e_emits++;
                        e_win = '0;
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++)
                                e_win = {e_win[63:0], img[e_row-2+i][e_col-2+j]};
                        e_xy = {12'(e_col-1), 12'(e_row-1)};
                    end
                    e_col++;
                    if (e_col == W) begin
                        e_col = 0;
                        e_row++;
                        if (e_row == H) e_row = 0;
                    end
                end
            end
        end
    endtask

    task automatic ready_loop();
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = 1'b0;
            endcase
        end
    endtask

    task automatic send(input logic [7:0] d, input logic sof);
        bit ok;
        int n;
        if (gap_en) begin
            bus.s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                bus.s_data = 8'($urandom);
                bus.s_sof  = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
        end
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_sof   = sof;
        ok = 0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("send_timeout", 72'(ok), 72'd1);
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input logic sof_first);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(8'(base + 8'(r*16 + c)), sof_first && r == 0 && c == 0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus.s_valid = 1'b0;
        while (k < 300) begin
            @(negedge clk);
            if (!bus.m_valid) break;
            k++;
        end
        if (k >= 300) check("drain_timeout", 72'(bus.m_valid), 72'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic main_seq();
        int s0, d0, x0, e0;
        logic [71:0] held;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("reset_s_ready", 72'(bus.s_ready), 72'd1);
        @(posedge clk);
        #1;

        // Basic frame, continuous stream
        s0 = got_q.size(); d0 = n_done; x0 = xy_q.size();
        send_frame(8'h00, 1'b1);
        drain();
        check("s1_count", 72'(got_q.size() - s0), 72'd6);
        check("s1_first", qget(s0), c_FIRST);
        check("s1_last", qget(s0 + 5), c_LAST);
        check("s1_done", 72'(n_done - d0), 72'd1);
`ifdef MEDWIN_COORD_EN
        check("s1_xy_first", 72'(xyget(x0)), 72'({12'd1, 12'd1}));
        check("s1_xy_last", 72'(xyget(x0 + 5)), 72'({12'd3, 12'd2}));
`endif

        // Downstream stall right after the first window
        rdy_mode = 2;
        @(posedge clk);
        #1;
        s0 = got_q.size(); d0 = n_done;
        for (int i = 0; i < 13; i++) send(8'(16*(i/W) + i%W), i == 0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h23;
        held = win_act();
        check("stall_first", held, c_FIRST);
        repeat (4) begin
            @(negedge clk);
            check("stall_s_ready", 72'(bus.s_ready), 72'd0);
            check("stall_m_valid", 72'(bus.m_valid), 72'd1);
            check("stall_hold", win_act(), held);
        end
        rdy_mode = 0;
        for (int i = 13; i < W*H; i++) send(8'(16*(i/W) + i%W), 1'b0);
        drain();
        check("s2_count", 72'(got_q.size() - s0), 72'd6);
        check("s2_first", qget(s0), c_FIRST);
        check("s2_last", qget(s0 + 5), c_LAST);
        check("s2_done", 72'(n_done - d0), 72'd1);

        // Back-to-back frames, second offset by 0x80
        s0 = got_q.size(); d0 = n_done;
        send_frame(8'h00, 1'b1);
        send_frame(8'h80, 1'b1);
        drain();
        check("s3_count", 72'(got_q.size() - s0), 72'd12);
        check("s3_f2_first", qget(s0 + 6), c_F2);
        check("s3_done", 72'(n_done - d0), 72'd2);

        // Frame truncated by s_sof at what would be (2,3)
        s0 = got_q.size(); d0 = n_done;
        for (int i = 0; i < 13; i++) send(8'(16*(i/W) + i%W), i == 0);
        send_frame(8'h00, 1'b1);
        drain();
        check("s4_count", 72'(got_q.size() - s0), 72'd7);
        check("s4_trunc_win", qget(s0), c_FIRST);
        check("s4_new_first", qget(s0 + 1), c_FIRST);
        check("s4_new_last", qget(s0 + 6), c_LAST);
        check("s4_done", 72'(n_done - d0), 72'd1);

        // Asynchronous reset with a window pending
        rdy_mode = 2;
        for (int i = 0; i < 13; i++) send(8'(16*(i/W) + i%W), i == 0);
        check("pre_rst_m_valid", 72'(bus.m_valid), 72'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_m_valid", 72'(bus.m_valid), 72'd0);
        check("async_window", win_act(), 72'd0);
        check("async_frame_done", 72'(bus.frame_done), 72'd0);
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        s0 = got_q.size(); d0 = n_done;
        send_frame(8'h00, 1'b0);
        drain();
        check("s5_count", 72'(got_q.size() - s0), 72'd6);
        check("s5_first", qget(s0), c_FIRST);
        check("s5_last", qget(s0 + 5), c_LAST);
        check("s5_done", 72'(n_done - d0), 72'd1);

        // Randomized data, gaps, backpressure and stray s_sof
        rdy_mode = 1;
        gap_en   = 1;
        s0 = got_q.size(); e0 = e_emits;
        for (int i = 0; i < 4*W*H; i++)
            send(8'($urandom), i == 0 || $urandom_range(0, 29) == 0);
        drain();
        check("rand_count", 72'(got_q.size() - s0), 72'(e_emits - e0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    endtask

    initial begin
        fork
            monitor_loop();
            ready_loop();
            main_seq();
            begin
                #2_000_000;
                $display("FAIL watchdog act=timeout exp=finish");
                $fatal(1, "watchdog expired");
            end
        join_any
    end
endmodule
`default_nettype wire
